// File: rtl/led_sequence_ctrl_if.sv
// Command channel for the LED sequencer: valid/ready handshake carrying
// mode, LED mask and burst repeat count.
interface led_sequence_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [1:0]       cmd_mask;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid, cmd_mode, cmd_mask, cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_mask, cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/led_sequence_ctrl.sv
// Command-driven LED sequencer: a tick prescaler plus a mode FSM that drives
// LED0/LED1 with phase-aligned OFF/ON/BLINK/BURST patterns.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | LEDs off, ready for a command
// SOLID     | LEDs = mask until the next command
// BLINK     | LEDs toggle between mask and off every tick, mask phase first
// BURST_ON  | burst on-phase, LEDs = mask, not preemptable
// BURST_OFF | burst off-phase, LEDs off, counts down remaining repeats
module led_sequence_ctrl #(
    parameter int TICK_DIV = 4194304,
    parameter int CNT_W    = 5
) (
    input  logic               iCE_CLK,
    input  logic               PIO1_02,
    led_sequence_ctrl_if.slave cmd,
    output logic               LED0,
    output logic               LED1,
    output logic               busy,
    output logic               done
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SOLID,
        BLINK,
        BURST_ON,
        BURST_OFF
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              accept;
    logic [1:0]        mask_q;
    logic [CNT_W-1:0]  remaining;

    // A running burst owns the LEDs until it completes.
    assign cmd.cmd_ready = (state != BURST_ON) && (state != BURST_OFF);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign tick          = (tick_cnt == TICK_LAST);
    assign busy          = (state != IDLE);

    // Phase prescaler; every accepted command restarts it so patterns are phase-aligned.
    always_ff @(posedge iCE_CLK or posedge PIO1_02) begin
        if (PIO1_02) begin
            tick_cnt <= '0;
        end else if (accept || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Mode FSM with registered LED drive and done pulse.
    always_ff @(posedge iCE_CLK or posedge PIO1_02) begin
        if (PIO1_02) begin
            state       <= IDLE;
            LED0        <= 1'b0;
            LED1        <= 1'b0;
            done        <= 1'b0;
            mask_q      <= 2'b00;
            remaining   <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mask_q    <= cmd.cmd_mask;
                remaining <= cmd.cmd_count;
                case (cmd.cmd_mode)
                    MODE_OFF: begin
                        state       <= IDLE;
                        {LED1, LED0} <= 2'b00;
                    end
                    MODE_ON: begin
                        state       <= SOLID;
                        {LED1, LED0} <= cmd.cmd_mask;
                    end
                    MODE_BLINK: begin
                        state       <= BLINK;
                        {LED1, LED0} <= cmd.cmd_mask;
                    end
                    default: begin
                        // A zero-length burst completes at once: no LED activity, just done.
                        if (cmd.cmd_count == '0) begin
                            state       <= IDLE;
                            {LED1, LED0} <= 2'b00;
                            done        <= 1'b1;
                        end else begin
                            state       <= BURST_ON;
                            {LED1, LED0} <= cmd.cmd_mask;
                        end
                    end
                endcase
            end else begin
                case (state)
                    IDLE, SOLID: begin
                    end
                    BLINK: begin
                        if (tick) begin
                            {LED1, LED0} <= ({LED1, LED0} == 2'b00) ? mask_q : 2'b00;
                        end
                    end
                    BURST_ON: begin
                        if (tick) begin
                            state       <= BURST_OFF;
                            {LED1, LED0} <= 2'b00;
                        end
                    end
                    BURST_OFF: begin
                        if (tick) begin
                            remaining <= remaining - CNT_W'(1);
                            // Last repeat: the decremented count reaches zero.
                            if (remaining == CNT_W'(1)) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state       <= BURST_ON;
                                {LED1, LED0} <= mask_q;
                            end
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        {LED1, LED0} <= 2'b00;
                    end
                endcase
            end
        end
    end

endmodule
